// File: rtl/cpu_pkg.sv
// Shared types and constants for the 4-requester bus arbiter.
package cpu_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    StIdle  = 1'b0,
    StOwned = 1'b1
  } arb_state_t;

  // Index of the set bit in a one-hot vector; returns 0 for an all-zero input.
  function automatic logic [1:0] oh2idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: searches upward from (ptr + 1) with wrap.
module rr_pick4
  import cpu_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_mask,
  input  logic [1:0]         i_ptr,
  output logic [NUM_REQ-1:0] o_win,
  output logic               o_valid
);

  logic [1:0] w_idx;

  // First asserted mask bit after the pointer wins; the pointer itself is checked last.
  always_comb begin
    o_win   = '0;
    o_valid = 1'b0;
    w_idx   = 2'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = i_ptr + 2'(k);
      if (!o_valid && i_mask[w_idx]) begin
        o_win[w_idx] = 1'b1;
        o_valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arb4.sv
// Four-requester round-robin bus arbiter with bounded hold time and shared output mux.
module bus_arb4
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  output logic [3:0]        gnt,
  output logic [1:0]        sel,
  output logic              busy,
  output logic [DATA_W-1:0] y
);

  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  arb_state_t  r_state;
  logic [3:0]  r_gnt;
  logic [1:0]  r_sel;
  logic [1:0]  r_last;
  logic        r_busy;
  logic [7:0]  r_hold;

  logic [3:0]  w_mask;
  logic [3:0]  w_win;
  logic        w_valid;
  logic [1:0]  w_win_idx;
  logic        w_owner_req;

  // While owned, the current owner is excluded so a preempt never re-picks it.
  always_comb begin
    w_mask = (r_state == StOwned) ? (req & ~r_gnt) : req;
  end

  assign w_owner_req = |(req & r_gnt);
  assign w_win_idx   = oh2idx(w_win);

  rr_pick4 u_pick (
    .i_mask  (w_mask),
    .i_ptr   (r_last),
    .o_win   (w_win),
    .o_valid (w_valid)
  );

  // Arbitration FSM with registered grant, select, busy and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_last  <= 2'd3;
      r_busy  <= 1'b0;
      r_hold  <= 8'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_valid) begin
            r_state <= StOwned;
            r_gnt   <= w_win;
            r_sel   <= w_win_idx;
            r_last  <= w_win_idx;
            r_busy  <= 1'b1;
            r_hold  <= 8'd0;
          end
        end
        StOwned: begin
          if (!w_owner_req || (r_hold == HoldLast && w_valid)) begin
            // Release or hold-limit preempt: hand over directly, or go idle if nobody waits.
            if (w_valid) begin
              r_gnt  <= w_win;
              r_sel  <= w_win_idx;
              r_last <= w_win_idx;
              r_hold <= 8'd0;
            end else begin
              r_state <= StIdle;
              r_gnt   <= 4'b0000;
              r_busy  <= 1'b0;
              r_hold  <= 8'd0;
            end
          end else if (r_hold != HoldLast) begin
            r_hold <= r_hold + 8'd1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_gnt   <= 4'b0000;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign sel  = r_sel;
  assign busy = r_busy;

  // Shared bus mux driven from registered select; zero whenever nobody owns the bus.
  always_comb begin
    y = '0;
    if (r_busy) begin
      unique case (r_sel)
        2'd0: y = d0;
        2'd1: y = d1;
        2'd2: y = d2;
        2'd3: y = d3;
        default: y = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arb4.sv
// Directed self-checking bench for bus_arb4 (DATA_W = 8, MAX_HOLD = 8).
module tb_bus_arb4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] d0, d1, d2, d3;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic [7:0] y;

  int n_cmp;
  int n_err;
  logic [3:0] req_at_edge;

  bus_arb4 #(
    .DATA_W   (8),
    .MAX_HOLD (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .d0    (d0),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .gnt   (gnt),
    .sel   (sel),
    .busy  (busy),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Capture req at each edge, then check grant legality mid-cycle.
  always @(posedge clk) req_at_edge = req;

  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      assert (($countones(gnt) <= 1) && ((gnt & ~req_at_edge) == 4'b0000))
      else begin
        n_err++;
        $error("FAIL gnt_legal: observed gnt %b req %b required one-hot-or-zero subset of req",
               gnt, req_at_edge);
      end
    end
  end

  initial begin
    int         order [5];
    logic [3:0] exp_g;

    n_cmp = 0;
    n_err = 0;
    req_at_edge = 4'b0000;
    rst_n = 1'b0;
    req   = 4'b0000;
    d0 = 8'h11; d1 = 8'h22; d2 = 8'h33; d3 = 8'h44;
    order = '{0, 1, 2, 3, 0};

    // Reset state
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_y", 32'(y), 32'h0);
    do_reset();

    // req = 0101 -> requester 0 first, then release hands over to 2
    req = 4'b0101;
    step();
    chk("s28_gnt0", 32'(gnt), 32'h1);
    chk("s28_sel0", 32'(sel), 32'h0);
    chk("s28_y0", 32'(y), 32'h11);
    chk("s28_busy", 32'(busy), 32'h1);
    req = 4'b0100;
    step();
    chk("s28_gnt2", 32'(gnt), 32'h4);
    chk("s28_sel2", 32'(sel), 32'h2);
    chk("s28_y2", 32'(y), 32'h33);
    req = 4'b0000;
    step();
    chk("s28_idle_gnt", 32'(gnt), 32'h0);
    chk("s28_idle_sel", 32'(sel), 32'h2);

    // All four requesting: 8 cycles each, order 0,1,2,3,0 with no gap
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << order[i];
      for (int c = 0; c < 8; c++) begin
        step();
        chk("s29_gnt", 32'(gnt), 32'(exp_g));
      end
    end
    req = 4'b0000;
    step();

    // Lone requester saturates its hold and keeps the grant
    req = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("s30_gnt", 32'(gnt), 32'h2);
    end
    chk("s30_y", 32'(y), 32'h22);
    req = 4'b0000;
    step();
    chk("s30_rel_gnt", 32'(gnt), 32'h0);
    chk("s30_rel_busy", 32'(busy), 32'h0);
    chk("s30_rel_y", 32'(y), 32'h0);
    chk("s30_rel_sel", 32'(sel), 32'h1);

    // Owner 3 releases as req0 rises: wrap to 0 with no bubble
    req = 4'b1000;
    step();
    chk("s31_gnt3", 32'(gnt), 32'h8);
    step();
    step();
    req = 4'b0001;
    d0  = 8'hA5;
    step();
    chk("s31_gnt0", 32'(gnt), 32'h1);
    chk("s31_y", 32'(y), 32'hA5);
    chk("s31_sel", 32'(sel), 32'h0);
    chk("s31_busy", 32'(busy), 32'h1);

    // Asynchronous reset mid-ownership
    req = 4'b0100;
    step();
    chk("s32_gnt2", 32'(gnt), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s32_rst_gnt", 32'(gnt), 32'h0);
    chk("s32_rst_busy", 32'(busy), 32'h0);
    chk("s32_rst_sel", 32'(sel), 32'h0);
    chk("s32_rst_y", 32'(y), 32'h0);
    req = 4'b1111;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
    chk("s32_first_gnt", 32'(gnt), 32'h1);
    chk("s32_first_y", 32'(y), 32'hA5);

    req = 4'b0000;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
